// File: rtl/irq_ctl.sv
// Interrupt front end for the 65C02 core: pin synchronisation, NMI edge latch,
// I-flag masking, NMI/IRQ priority, vector low byte selection and WAI/STP halt.
module irq_ctl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       irq_n,
    input  logic       nmi_n,
    input  logic       sync,
    input  logic       I,
    input  logic       wai,
    input  logic       stp,
    input  logic       brk,
    input  logic       vec_ack,
    output logic       int_req,
    output logic [7:0] vec_lo,
    output logic       nmi_pending,
    output logic       halt
);

    localparam logic [7:0] VEC_NMI = 8'hFA;
    localparam logic [7:0] VEC_RST = 8'hFC;
    localparam logic [7:0] VEC_IRQ = 8'hFE;

    typedef enum logic [2:0] {ST_RST, ST_RUN, ST_ACK, ST_WAIT, ST_STOP} state_t;
    typedef enum logic [1:0] {K_IRQ, K_NMI, K_BRK} kind_t;

    state_t                 state;
    kind_t                  kind;
    logic [SYNC_STAGES-1:0] irq_sync;
    logic [SYNC_STAGES-1:0] nmi_sync;
    logic                   nmi_s_d;
    logic                   nmi_latch;
    logic                   irq_s;
    logic                   nmi_s;
    logic                   irq_act;
    logic                   nmi_edge;
    logic                   nmi_clr;
    logic                   take_int;

    assign irq_s       = irq_sync[SYNC_STAGES-1];
    assign nmi_s       = nmi_sync[SYNC_STAGES-1];
    assign irq_act     = ~irq_s;
    assign nmi_edge    = nmi_s_d & ~nmi_s;
    assign nmi_clr     = vec_ack & (kind == K_NMI);
    assign take_int    = sync & int_req;
    assign nmi_pending = nmi_latch;

    // NOTE: synchronisers reset to 1 (pins idle high) so releasing reset never fakes an NMI edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_sync <= '1;
            nmi_sync <= '1;
            nmi_s_d  <= 1'b1;
        end else begin
            irq_sync <= {irq_sync[SYNC_STAGES-2:0], irq_n};
            nmi_sync <= {nmi_sync[SYNC_STAGES-2:0], nmi_n};
            nmi_s_d  <= nmi_s;
        end
    end

    // A new edge outranks a service clear landing in the same cycle.
    always_ff @(posedge clk) begin
        if (reset)         nmi_latch <= 1'b0;
        else if (nmi_edge) nmi_latch <= 1'b1;
        else if (nmi_clr)  nmi_latch <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_RST;
            kind    <= K_IRQ;
            int_req <= 1'b0;
            vec_lo  <= VEC_RST;
            halt    <= 1'b0;
        end else begin
            case (state)
                ST_RST: begin
                    int_req <= 1'b0;
                    vec_lo  <= VEC_RST;
                    if (vec_ack) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (take_int) begin
                        int_req <= 1'b0;
                        state   <= ST_ACK;
                        if (nmi_latch) begin
                            kind   <= K_NMI;
                            vec_lo <= VEC_NMI;
                        end else begin
                            kind   <= K_IRQ;
                            vec_lo <= VEC_IRQ;
                        end
                    end else if (stp) begin
                        int_req <= 1'b0;
                        halt    <= 1'b1;
                        state   <= ST_STOP;
                    end else if (wai) begin
                        int_req <= 1'b0;
                        halt    <= 1'b1;
                        state   <= ST_WAIT;
                    end else begin
                        int_req <= nmi_latch | (irq_act & ~I);
                        if (brk) begin
                            kind   <= K_BRK;
                            vec_lo <= VEC_IRQ;
                        end
                    end
                end
                ST_ACK: begin
                    int_req <= 1'b0;
                    if (vec_ack) state <= ST_RUN;
                end
                ST_WAIT: begin
                    // Wake ignores I; masking is re-applied once back in RUN.
                    int_req <= 1'b0;
                    if (nmi_latch | irq_act) begin
                        halt  <= 1'b0;
                        state <= ST_RUN;
                    end
                end
                ST_STOP: begin
                    int_req <= 1'b0;
                    halt    <= 1'b1;
                end
                default: begin
                    int_req <= 1'b0;
                    halt    <= 1'b0;
                    state   <= ST_RST;
                end
            endcase
        end
    end

endmodule
